// File: rtl/lasd_ctrl_pkg.sv
// rtl/lasd_ctrl_pkg.sv - shared types and encodings for the LASD register-file control FSM
package lasd_ctrl_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

endpackage

// File: rtl/riscv_field_decode.sv
// rtl/riscv_field_decode.sv - combinational RV32I subset decode of the instruction register
module riscv_field_decode
    import lasd_ctrl_pkg::*;
#(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic [31:0]   ir,
    output logic [AW-1:0] ra1,
    output logic [AW-1:0] ra2,
    output logic [AW-1:0] wa3,
    output logic [N-1:0]  imm,
    output alu_ctrl_t     alu_ctrl,
    output logic          alu_src,
    output logic          legal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       is_r;
    logic       op_ok;
    logic       regs_ok;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    assign ra1 = ir[15 +: AW];
    assign ra2 = ir[20 +: AW];
    assign wa3 = ir[7 +: AW];

    // Narrow datapaths only see low immediate bits, which equal the sign-extended value's low bits.
    generate
        if (N <= 12) begin : g_imm_trunc
            assign imm = ir[20 +: N];
        end else begin : g_imm_sext
            assign imm = {{(N-12){ir[31]}}, ir[31:20]};
        end
    endgenerate

    always_comb begin
        alu_ctrl = ALU_ADD;
        alu_src  = 1'b0;
        op_ok    = 1'b0;
        is_r     = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                is_r = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, F3_ADD}: begin op_ok = 1'b1; alu_ctrl = ALU_ADD; end
                    {F7_SUB,  F3_ADD}: begin op_ok = 1'b1; alu_ctrl = ALU_SUB; end
                    {F7_BASE, F3_SLT}: begin op_ok = 1'b1; alu_ctrl = ALU_SLT; end
                    {F7_BASE, F3_OR }: begin op_ok = 1'b1; alu_ctrl = ALU_OR;  end
                    {F7_BASE, F3_AND}: begin op_ok = 1'b1; alu_ctrl = ALU_AND; end
                    default:           op_ok = 1'b0;
                endcase
            end
            OPC_ITYPE: begin
                alu_src = 1'b1;
                case (funct3)
                    F3_ADD:  begin op_ok = 1'b1; alu_ctrl = ALU_ADD; end
                    F3_SLT:  begin op_ok = 1'b1; alu_ctrl = ALU_SLT; end
                    F3_OR:   begin op_ok = 1'b1; alu_ctrl = ALU_OR;  end
                    F3_AND:  begin op_ok = 1'b1; alu_ctrl = ALU_AND; end
                    default: op_ok = 1'b0;
                endcase
            end
            default: op_ok = 1'b0;
        endcase
    end

    // The rs2 field holds immediate bits for I-type, so only R-type range-checks it.
    assign regs_ok = ((rs1 >> AW) == 5'd0) && ((rd >> AW) == 5'd0) &&
                     (!is_r || ((rs2 >> AW) == 5'd0));

    assign legal = op_ok && regs_ok;

endmodule

// File: rtl/regfile_ctrl_fsm.sv
// rtl/regfile_ctrl_fsm.sv - multicycle IDLE/DECODE/EXEC/WB controller driving the register file
module regfile_ctrl_fsm
    import lasd_ctrl_pkg::*;
#(
    parameter int N    = 8,
    parameter int AW   = 3,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic            instr_valid,
    output logic            instr_ready,
    output logic [AW-1:0]   ra1,
    output logic [AW-1:0]   ra2,
    output logic [AW-1:0]   wa3,
    output logic            we3,
    output logic [N-1:0]    imm,
    output logic            alu_src,
    output alu_ctrl_t       alu_ctrl,
    output logic            illegal,
    output logic            busy,
    output logic [CNTW-1:0] retired
);

    state_t            state_q, state_d;
    logic [31:0]       ir_q, ir_d;
    logic [CNTW-1:0]   retired_q, retired_d;
    logic              init_q;
    logic              accept;
    logic              legal;

    // init_q keeps instr_ready low until the first edge after reset release.
    assign instr_ready = init_q && (state_q == S_IDLE);
    assign accept      = instr_ready && instr_valid;
    assign busy        = (state_q != S_IDLE);
    assign we3         = (state_q == S_WB) && legal && (wa3 != '0);
    assign illegal     = (state_q == S_WB) && !legal;
    assign retired     = retired_q;

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB: begin
                state_d = S_IDLE;
                if (legal) begin
                    retired_d = retired_q + {{(CNTW-1){1'b0}}, 1'b1};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            retired_q <= '0;
            init_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            init_q    <= 1'b1;
        end
    end

    // Fields decode straight from IR, so they hold from DECODE through WB and into IDLE.
    riscv_field_decode #(
        .N  (N),
        .AW (AW)
    ) u_decode (
        .ir       (ir_q),
        .ra1      (ra1),
        .ra2      (ra2),
        .wa3      (wa3),
        .imm      (imm),
        .alu_ctrl (alu_ctrl),
        .alu_src  (alu_src),
        .legal    (legal)
    );

endmodule

// File: tb/tb_regfile_ctrl_fsm.sv
// tb/tb_regfile_ctrl_fsm.sv - table-driven bench for regfile_ctrl_fsm
module tb_regfile_ctrl_fsm;
    import lasd_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;

    logic        instr_ready, we3, alu_src, illegal, busy;
    logic [2:0]  ra1, ra2, wa3;
    logic [7:0]  imm;
    logic [2:0]  alu_ctrl;
    logic [15:0] retired;

    logic        n_instr_ready, n_we3, n_alu_src, n_illegal, n_busy;
    logic [2:0]  n_ra1, n_ra2, n_wa3;
    logic [7:0]  n_imm;
    logic [2:0]  n_alu_ctrl;
    logic [1:0]  n_retired;

    int checks   = 0;
    int failures = 0;
    int model_ret = 0;

    regfile_ctrl_fsm #(.N(8), .AW(3), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .ra1(ra1), .ra2(ra2), .wa3(wa3), .we3(we3),
        .imm(imm), .alu_src(alu_src), .alu_ctrl(alu_ctrl), .illegal(illegal),
        .busy(busy), .retired(retired)
    );

    // Narrow-counter instance sees the same stimulus and exercises retired wrap-around.
    regfile_ctrl_fsm #(.N(8), .AW(3), .CNTW(2)) dut_n (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(n_instr_ready), .ra1(n_ra1), .ra2(n_ra2), .wa3(n_wa3), .we3(n_we3),
        .imm(n_imm), .alu_src(n_alu_src), .alu_ctrl(n_alu_ctrl), .illegal(n_illegal),
        .busy(n_busy), .retired(n_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  ra1, ra2, wa3;
        logic [7:0]  imm;
        logic        alu_src;
        logic [2:0]  alu_ctrl;
        logic        chk_alu;
        logic        we3;
        logic        ill;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready_timeout", {31'd0, instr_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        wait_ready();
        instr = v.instr;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = $urandom;
        @(negedge clk);
        chk("dec_busy",  {31'd0, busy}, 32'd1);
        chk("dec_ready", {31'd0, instr_ready}, 32'd0);
        chk("dec_ra1",   {29'd0, ra1}, {29'd0, v.ra1});
        chk("dec_ra2",   {29'd0, ra2}, {29'd0, v.ra2});
        chk("dec_wa3",   {29'd0, wa3}, {29'd0, v.wa3});
        chk("dec_imm",   {24'd0, imm}, {24'd0, v.imm});
        chk("dec_alu_src", {31'd0, alu_src}, {31'd0, v.alu_src});
        if (v.chk_alu) chk("dec_alu_ctrl", {29'd0, alu_ctrl}, {29'd0, v.alu_ctrl});
        chk("dec_we3",   {31'd0, we3}, 32'd0);
        chk("dec_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        chk("exec_we3",  {31'd0, we3}, 32'd0);
        chk("exec_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        chk("wb_we3",    {31'd0, we3}, {31'd0, v.we3});
        chk("wb_illegal", {31'd0, illegal}, {31'd0, v.ill});
        chk("wb_wa3",    {29'd0, wa3}, {29'd0, v.wa3});
        if (!v.ill) model_ret++;
        @(negedge clk);
        chk("post_ready", {31'd0, instr_ready}, 32'd1);
        chk("post_we3",   {31'd0, we3}, 32'd0);
        chk("post_ra1_hold", {29'd0, ra1}, {29'd0, v.ra1});
        chk("retired",    {16'd0, retired}, model_ret);
        chk("retired_narrow", {30'd0, n_retired}, model_ret & 3);
    endtask

    initial begin
        //            instr         ra1   ra2   wa3   imm    src  alu      chk  we3  ill
        vecs[0]  = '{32'hFFF08193, 3'd1, 3'd7, 3'd3, 8'hFF, 1'b1, ALU_ADD, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{32'h40628133, 3'd5, 3'd6, 3'd2, 8'h06, 1'b0, ALU_SUB, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{32'h00208033, 3'd1, 3'd2, 3'd0, 8'h02, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{32'h002084B3, 3'd1, 3'd2, 3'd1, 8'h02, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{32'h00312233, 3'd2, 3'd3, 3'd4, 8'h03, 1'b0, ALU_SLT, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{32'h007362B3, 3'd6, 3'd7, 3'd5, 8'h07, 1'b0, ALU_OR,  1'b1, 1'b1, 1'b0};
        vecs[6]  = '{32'h0010F3B3, 3'd1, 3'd1, 3'd7, 8'h01, 1'b0, ALU_AND, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{32'h07F16093, 3'd2, 3'd7, 3'd1, 8'h7F, 1'b1, ALU_OR,  1'b1, 1'b1, 1'b0};
        vecs[8]  = '{32'h0051A113, 3'd3, 3'd5, 3'd2, 8'h05, 1'b1, ALU_SLT, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{32'hF803F313, 3'd7, 3'd0, 3'd6, 8'h80, 1'b1, ALU_AND, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{32'h407362B3, 3'd6, 3'd7, 3'd5, 8'h07, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{32'h00012083, 3'd2, 3'd0, 3'd1, 8'h00, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{32'h00140093, 3'd0, 3'd1, 3'd1, 8'h01, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{32'h010080B3, 3'd1, 3'd0, 3'd1, 8'h10, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b1};

        rst = 1'b0;
        instr = 32'hFFF08193;
        instr_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready",   {31'd0, instr_ready}, 32'd0);
        chk("rst_busy",    {31'd0, busy}, 32'd0);
        chk("rst_we3",     {31'd0, we3}, 32'd0);
        chk("rst_ra1",     {29'd0, ra1}, 32'd0);
        chk("rst_imm",     {24'd0, imm}, 32'd0);
        chk("rst_retired", {16'd0, retired}, 32'd0);
        instr_valid = 1'b0;
        rst = 1'b1;
        chk("rel_ready_before_edge", {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        chk("rel_ready", {31'd0, instr_ready}, 32'd1);
        chk("rel_retired", {16'd0, retired}, 32'd0);

        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        begin
            logic [31:0] prog[3];
            logic [2:0]  prog_rd[3];
            int acc = 0;
            int wbn = 0;
            prog[0] = 32'hFFF08193; prog_rd[0] = 3'd3;
            prog[1] = 32'h40628133; prog_rd[1] = 3'd2;
            prog[2] = 32'h00312233; prog_rd[2] = 3'd4;
            wait_ready();
            instr = prog[0];
            instr_valid = 1'b1;
            for (int c = 0; c < 12; c++) begin
                chk("b2b_ready", {31'd0, instr_ready}, {31'd0, (c % 4) == 0});
                chk("b2b_we3",   {31'd0, we3},         {31'd0, (c % 4) == 3});
                if (instr_ready) acc++;
                if ((c % 4) == 3) begin
                    chk("b2b_wa3", {29'd0, wa3}, {29'd0, prog_rd[wbn]});
                    wbn++;
                end
                @(posedge clk);
                #1;
                if (acc < 3) instr = prog[acc];
                @(negedge clk);
            end
            instr_valid = 1'b0;
            chk("b2b_accepts", acc, 32'd3);
            model_ret += 3;
            @(negedge clk);
            chk("b2b_retired", {16'd0, retired}, model_ret);
            chk("b2b_retired_narrow", {30'd0, n_retired}, model_ret & 3);
            chk("b2b_idle", {31'd0, busy}, 32'd0);
        end

        wait_ready();
        instr = 32'h00108093;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("exec_state_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_busy",    {31'd0, busy}, 32'd0);
        chk("abort_wa3",     {29'd0, wa3}, 32'd0);
        chk("abort_ra1",     {29'd0, ra1}, 32'd0);
        chk("abort_alu_src", {31'd0, alu_src}, 32'd0);
        chk("abort_retired", {16'd0, retired}, 32'd0);
        model_ret = 0;
        begin
            int we3_seen = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (we3) we3_seen++;
            end
            rst = 1'b1;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (we3) we3_seen++;
            end
            chk("abort_no_we3", we3_seen, 32'd0);
        end
        chk("abort_ready_after", {31'd0, instr_ready}, 32'd1);

        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
